// File: rtl/icache_rf_pkg.sv
// icache_rf_pkg: shared types and default geometry for the iCache way array.
//   flush_state_e : flush sequencer states (IDLE / SWEEP / DONE)
//   idx_t         : array index at the default geometry
//   way_mask_t    : one bit per way
//   way_entry_t   : one way entry (tag + payload)
//   DATA_WORDS    : array depth at the default geometry
package icache_rf_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 44;
  localparam int N_READ_DEF     = 4;
  localparam int N_WAY_DEF      = 4;
  localparam int DATA_WORDS     = 2**ADDR_WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } flush_state_e;

  typedef logic [ADDR_WIDTH_DEF-1:0] idx_t;
  typedef logic [N_WAY_DEF-1:0]      way_mask_t;
  typedef logic [DATA_WIDTH_DEF-1:0] way_entry_t;

endpackage

// File: rtl/icache_rf_flush_fsm.sv
// icache_rf_flush_fsm: whole-array flush sequencer.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_FlushReq     : flush request, sampled only in IDLE
//   o_FlushBusy    : high in SWEEP and DONE (DATA_WORDS+1 cycles)
//   o_FlushDone    : one-cycle pulse in the DONE state
//   o_SweepEn      : clear valid bits at o_SweepIdx this cycle
//   o_SweepIdx     : index currently being swept
module icache_rf_flush_fsm
  import icache_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_FlushReq,
  output logic                  o_FlushBusy,
  output logic                  o_FlushDone,
  output logic                  o_SweepEn,
  output logic [ADDR_WIDTH-1:0] o_SweepIdx
);

  flush_state_e          state;
  logic [ADDR_WIDTH-1:0] sweep_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      sweep_cnt   <= '0;
      o_FlushBusy <= 1'b0;
      o_FlushDone <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_FlushDone <= 1'b0;
          if (i_FlushReq) begin
            state       <= SWEEP;
            sweep_cnt   <= '0;
            o_FlushBusy <= 1'b1;
          end
        end
        SWEEP: begin
          // Counter wraps naturally to 0 after the last index.
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == '1) begin
            state       <= DONE;
            o_FlushDone <= 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          o_FlushBusy <= 1'b0;
          o_FlushDone <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          o_FlushBusy <= 1'b0;
          o_FlushDone <= 1'b0;
        end
      endcase
    end
  end

  assign o_SweepEn  = (state == SWEEP);
  assign o_SweepIdx = sweep_cnt;

endmodule

// File: rtl/icache_way_array_mp.sv
// icache_way_array_mp: N_WAY-way, 2**ADDR_WIDTH-deep iCache way array with
// N_READ registered read ports, per-entry valid bits, single-entry
// invalidate and a sequenced whole-array flush.
//   Read ports  : i_ReadEnable/i_ReadAddr -> o_ReadValid/o_ReadData/o_EntryValid (1 cycle)
//   Refill      : i_WriteEnable (way mask), i_WriteAddr, i_WriteData
//   Invalidate  : i_InvalEnable, i_InvalAddr, i_InvalWay
//   Flush       : i_FlushReq -> o_FlushBusy, o_FlushDone
// Optional feature macro ICACHE_WAY_ARRAY_BYPASS_EN: same-cycle write /
// invalidate results are forwarded to reads of the same index.
module icache_way_array_mp
  import icache_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N_READ     = N_READ_DEF,
  parameter int N_WAY      = N_WAY_DEF
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst_n,
  input  logic [N_READ-1:0]                            i_ReadEnable,
  input  logic [N_READ-1:0][ADDR_WIDTH-1:0]            i_ReadAddr,
  output logic [N_READ-1:0]                            o_ReadValid,
  output logic [N_READ-1:0][N_WAY-1:0][DATA_WIDTH-1:0] o_ReadData,
  output logic [N_READ-1:0][N_WAY-1:0]                 o_EntryValid,
  input  logic [N_WAY-1:0]                             i_WriteEnable,
  input  logic [ADDR_WIDTH-1:0]                        i_WriteAddr,
  input  logic [DATA_WIDTH-1:0]                        i_WriteData,
  input  logic                                         i_InvalEnable,
  input  logic [ADDR_WIDTH-1:0]                        i_InvalAddr,
  input  logic [N_WAY-1:0]                             i_InvalWay,
  input  logic                                         i_FlushReq,
  output logic                                         o_FlushBusy,
  output logic                                         o_FlushDone
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0][N_WAY-1:0][DATA_WIDTH-1:0] data_mem;
  logic [DEPTH-1:0][N_WAY-1:0]                 valid_mem;

  logic                  sweep_en;
  logic [ADDR_WIDTH-1:0] sweep_idx;

  icache_rf_flush_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_flush_fsm (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_FlushReq  (i_FlushReq),
    .o_FlushBusy (o_FlushBusy),
    .o_FlushDone (o_FlushDone),
    .o_SweepEn   (sweep_en),
    .o_SweepIdx  (sweep_idx)
  );

  // Array update: sweep clear while flushing, otherwise invalidate then
  // refill. The refill assignments come last so they win on overlap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_mem  <= '0;
      valid_mem <= '0;
    end else if (sweep_en) begin
      valid_mem[sweep_idx] <= '0;
    end else if (!o_FlushBusy) begin
      for (int w = 0; w < N_WAY; w++) begin
        if (i_InvalEnable && i_InvalWay[w]) valid_mem[i_InvalAddr][w] <= 1'b0;
      end
      for (int w = 0; w < N_WAY; w++) begin
        if (i_WriteEnable[w]) begin
          data_mem[i_WriteAddr][w]  <= i_WriteData;
          valid_mem[i_WriteAddr][w] <= 1'b1;
        end
      end
    end
  end

  // Stage p0: array lookup (plus optional forwarding)
  logic [N_READ-1:0][N_WAY-1:0][DATA_WIDTH-1:0] rd_data_p0;
  logic [N_READ-1:0][N_WAY-1:0]                 rd_vld_p0;

  always_comb begin
    rd_data_p0 = '0;
    rd_vld_p0  = '0;
    for (int p = 0; p < N_READ; p++) begin
      rd_data_p0[p] = data_mem[i_ReadAddr[p]];
      rd_vld_p0[p]  = valid_mem[i_ReadAddr[p]];
`ifdef ICACHE_WAY_ARRAY_BYPASS_EN
      if (!o_FlushBusy) begin
        for (int w = 0; w < N_WAY; w++) begin
          if (i_InvalEnable && i_InvalWay[w] && (i_InvalAddr == i_ReadAddr[p]))
            rd_vld_p0[p][w] = 1'b0;
          if (i_WriteEnable[w] && (i_WriteAddr == i_ReadAddr[p])) begin
            rd_data_p0[p][w] = i_WriteData;
            rd_vld_p0[p][w]  = 1'b1;
          end
        end
      end
`endif
      if (o_FlushBusy) rd_vld_p0[p] = '0;
    end
  end

  // Stage p1: registered read outputs; disabled ports hold their data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ReadValid  <= '0;
      o_ReadData   <= '0;
      o_EntryValid <= '0;
    end else begin
      o_ReadValid <= i_ReadEnable;
      for (int p = 0; p < N_READ; p++) begin
        if (i_ReadEnable[p]) begin
          o_ReadData[p]   <= rd_data_p0[p];
          o_EntryValid[p] <= rd_vld_p0[p];
        end
      end
    end
  end

endmodule
